lbuf_pingpong: RTL and testbench

//  Parametrised double-buffered sprite line buffer with transparent-skip writes and clear-on-read scan-out.
//  The sprite engine fills the write bank while video scans the display bank; SWAP exchanges them at line start.

---
 rtl/lbuf_pingpong.sv | 169 ++++++++++++++++
 tb/tb_lbuf_pingpong.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/lbuf_pingpong.sv
// lbuf_pingpong: double-buffered sprite line buffer.
// The sprite side writes into bank BANK through a 3-stage pipeline that skips
// transparent pixels; the scan side reads bank ~BANK and clears each cell it reads.
// A clear sequencer zeroes both banks after every reset.
// Optional feature macro: LBUF_OPAQUE_FIRST_EN (first opaque pixel wins).
module lbuf_pingpong #(
  parameter int              AW    = 9,
  parameter int              DW    = 8,
  parameter logic [DW-1:0]   TMASK = {DW{1'b1}}
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          SWAP,
  input  logic          WR,
  input  logic [AW-1:0] WAD,
  input  logic [DW-1:0] WDI,
  input  logic          RD,
  input  logic [AW-1:0] RAD,
  output logic [DW-1:0] DO,
  output logic          BANK,
  output logic          BUSY
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] sweep_q, sweep_d;
  logic          run;

  logic          bank_q, bank_d;

  logic          s1_vld_q, s1_vld_d;
  logic          s1_bank_q, s1_bank_d;
  logic [AW-1:0] s1_addr_q, s1_addr_d;
  logic [DW-1:0] s1_data_q, s1_data_d;

  logic          s2_vld_q, s2_vld_d;
  logic          s2_bank_q, s2_bank_d;
  logic [AW-1:0] s2_addr_q, s2_addr_d;
  logic [DW-1:0] s2_data_q, s2_data_d;

  logic          rd_vld_q, rd_vld_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;

  logic [DW-1:0] do_q, do_d;
  logic [DW-1:0] rd_cell;

  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];

`ifdef LBUF_OPAQUE_FIRST_EN
  logic [DW-1:0] s1_cell;
  logic [DW-1:0] s1_existing;
`endif

  // Sequencer next state: sweep every address once, then run until reset.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      ST_CLEAR: begin
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == {AW{1'b1}}) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Sequencer outputs: host ports are live only once the sweep has finished.
  always_comb begin
    run  = (state_q == ST_RUN);
    BUSY = (state_q == ST_CLEAR);
  end

`ifdef LBUF_OPAQUE_FIRST_EN
  // Current value of the S1 cell as it will be once this edge's clear/commit land.
  always_comb begin
    s1_cell     = s1_bank_q ? mem1[s1_addr_q] : mem0[s1_addr_q];
    s1_existing = s1_cell;
    if (rd_vld_q && (rd_bank_q == s1_bank_q) && (rd_addr_q == s1_addr_q))
      s1_existing = '0;
    else if (s2_vld_q && (s2_bank_q == s1_bank_q) && (s2_addr_q == s1_addr_q))
      s1_existing = s2_data_q;
  end
`endif

  // Bank toggle, write pipeline and read-port next values.
  always_comb begin
    bank_d    = bank_q ^ (run & SWAP);

    s1_vld_d  = run && WR && ((WDI & TMASK) != '0);
    s1_bank_d = bank_q;
    s1_addr_d = WAD;
    s1_data_d = WDI;

`ifdef LBUF_OPAQUE_FIRST_EN
    s2_vld_d  = s1_vld_q && ((s1_existing & TMASK) == '0);
`else
    s2_vld_d  = s1_vld_q;
`endif
    s2_bank_d = s1_bank_q;
    s2_addr_d = s1_addr_q;
    s2_data_d = s1_data_q;

    rd_vld_d  = run && RD;
    rd_bank_d = ~bank_q;
    rd_addr_d = RAD;

    rd_cell   = rd_bank_q ? mem1[rd_addr_q] : mem0[rd_addr_q];
    do_d      = do_q;
    if (rd_vld_q) begin
      if (s2_vld_q && (s2_bank_q == rd_bank_q) && (s2_addr_q == rd_addr_q))
        do_d = s2_data_q;
      else
        do_d = rd_cell;
    end
  end

  // Control and pipeline registers; reset drops everything in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_CLEAR;
      sweep_q  <= '0;
      bank_q   <= 1'b0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      rd_vld_q <= 1'b0;
      do_q     <= '0;
    end else begin
      state_q   <= state_d;
      sweep_q   <= sweep_d;
      bank_q    <= bank_d;
      s1_vld_q  <= s1_vld_d;
      s1_bank_q <= s1_bank_d;
      s1_addr_q <= s1_addr_d;
      s1_data_q <= s1_data_d;
      s2_vld_q  <= s2_vld_d;
      s2_bank_q <= s2_bank_d;
      s2_addr_q <= s2_addr_d;
      s2_data_q <= s2_data_d;
      rd_vld_q  <= rd_vld_d;
      rd_bank_q <= rd_bank_d;
      rd_addr_q <= rd_addr_d;
      do_q      <= do_d;
    end
  end

  // Bank RAM writes: sweep clear, or commit followed by read-clear (clear lands last).
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (!run) begin
        mem0[sweep_q] <= '0;
        mem1[sweep_q] <= '0;
      end else begin
        if (s2_vld_q && !s2_bank_q) mem0[s2_addr_q] <= s2_data_q;
        if (s2_vld_q &&  s2_bank_q) mem1[s2_addr_q] <= s2_data_q;
        if (rd_vld_q && !rd_bank_q) mem0[rd_addr_q] <= '0;
        if (rd_vld_q &&  rd_bank_q) mem1[rd_addr_q] <= '0;
      end
    end
  end

  assign DO   = do_q;
  assign BANK = bank_q;

endmodule

// File: tb/tb_lbuf_pingpong.sv
// Bench for lbuf_pingpong: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a queue-based line-buffer model.
module tb_lbuf_pingpong;

  localparam int          AW    = 4;
  localparam int          DW    = 8;
  localparam int          NCELL = 16;
  localparam logic [7:0]  TMASK = 8'h0F;
`ifdef LBUF_OPAQUE_FIRST_EN
  localparam bit OPAQUE_FIRST = 1'b1;
`else
  localparam bit OPAQUE_FIRST = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RESET, SWAP, WR, RD;
  logic [AW-1:0] WAD, RAD;
  logic [DW-1:0] WDI;
  logic [DW-1:0] DO;
  logic          BANK, BUSY;

  int checks = 0;
  int errors = 0;

  lbuf_pingpong #(.AW(AW), .DW(DW), .TMASK(TMASK)) dut (
    .CLK(CLK), .RESET(RESET), .SWAP(SWAP), .WR(WR), .WAD(WAD), .WDI(WDI),
    .RD(RD), .RAD(RAD), .DO(DO), .BANK(BANK), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Reference model state
  typedef struct {
    int         due;
    bit         bank;
    int         addr;
    logic [7:0] data;
  } wr_t;

  logic [7:0] mmem [0:1][0:NCELL-1];
  wr_t        wq[$];
  bit         m_valid = 1'b0;
  bit         m_bank;
  logic [7:0] m_do;
  int         clear_left;
  bit         rd_pend;
  bit         rd_b;
  int         rd_a;
  int         cyc = 0;

  task automatic check_output(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: per edge, commits due now, then the pending read, then new issues.
  always @(posedge CLK) begin
    if (RESET) begin
      m_valid    = 1'b1;
      m_bank     = 1'b0;
      m_do       = 8'h00;
      clear_left = NCELL;
      rd_pend    = 1'b0;
      wq.delete();
      for (int b = 0; b < 2; b++)
        for (int a = 0; a < NCELL; a++) mmem[b][a] = 8'h00;
    end else if (m_valid) begin
      wr_t w;
      while (wq.size() > 0 && wq[0].due == cyc) begin
        w = wq.pop_front();
        if (!OPAQUE_FIRST || ((mmem[w.bank][w.addr] & TMASK) == 8'h00))
          mmem[w.bank][w.addr] = w.data;
      end
      if (rd_pend) begin
        m_do = mmem[rd_b][rd_a];
        mmem[rd_b][rd_a] = 8'h00;
        rd_pend = 1'b0;
      end
      if (clear_left > 0) begin
        clear_left--;
      end else begin
        if (WR && ((WDI & TMASK) != 8'h00)) begin
          w.due = cyc + 2; w.bank = m_bank; w.addr = int'(WAD); w.data = WDI;
          wq.push_back(w);
        end
        if (RD) begin
          rd_pend = 1'b1;
          rd_b    = ~m_bank;
          rd_a    = int'(RAD);
        end
        if (SWAP) m_bank = ~m_bank;
      end
    end
    cyc++;
  end

  // Compare every cycle, away from the active edge.
  always @(negedge CLK) begin
    if (m_valid) begin
      check_output("model_do",   32'(DO),   32'(m_do));
      check_output("model_bank", 32'(BANK), 32'(m_bank));
      check_output("model_busy", 32'(BUSY), 32'(clear_left > 0));
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  task automatic do_write(input int a, input int d);
    WR = 1'b1; WAD = AW'(a); WDI = DW'(d);
    @(negedge CLK);
    WR = 1'b0;
  endtask

  task automatic do_swap();
    SWAP = 1'b1;
    @(negedge CLK);
    SWAP = 1'b0;
  endtask

  task automatic read_check(input int a, input int exp, input string nm);
    RD = 1'b1; RAD = AW'(a);
    @(negedge CLK);
    RD = 1'b0;
    @(negedge CLK);
    check_output(nm, 32'(DO), 32'(exp));
  endtask

  task automatic apply_stimulus(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      WR   = 1'($urandom_range(1));
      WAD  = AW'($urandom_range(NCELL - 1));
      WDI  = DW'($urandom);
      if ($urandom_range(3) == 0) WDI = WDI & 8'hF0;
      RD   = 1'($urandom_range(1));
      RAD  = AW'($urandom_range(NCELL - 1));
      SWAP = ($urandom_range(7) == 0);
      RESET = (i == ncyc / 2);
      @(negedge CLK);
    end
    WR = 1'b0; RD = 1'b0; SWAP = 1'b0; RESET = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    RESET = 1'b1; SWAP = 1'b0; WR = 1'b0; RD = 1'b0;
    WAD = '0; RAD = '0; WDI = '0;
    @(negedge CLK);
    RESET = 1'b0;

    // T1: reset state and sweep length
    check_output("t1_bank", 32'(BANK), 32'h0);
    check_output("t1_do",   32'(DO),   32'h0);
    busy_cnt = 0;
    while (BUSY === 1'b1 && busy_cnt < 100) begin
      busy_cnt++;
      @(negedge CLK);
    end
    check_output("t1_busy_cycles", 32'(busy_cnt), 32'd16);
    for (int a = 0; a < NCELL; a++) read_check(a, 0, "t1_bank1_zero");
    do_swap();
    for (int a = 0; a < NCELL; a++) read_check(a, 0, "t1_bank0_zero");

    // T2: fill then scan, then re-scan sees cleared cells
    for (int a = 0; a < 15; a++) do_write(a, 8'h11 + a);
    idle(2);
    do_swap();
    for (int a = 0; a < 15; a++) read_check(a, 8'h11 + a, "t2_scan");
    for (int a = 0; a < 15; a++) read_check(a, 0, "t2_rescan_zero");

    // T3: transparent write leaves existing pixel
    do_write(5, 8'h07);
    do_write(5, 8'h30);
    idle(3);
    do_swap();
    read_check(5, 8'h07, "t3_transparent_skip");

    // T4: back-to-back writes to one address
    do_write(3, 8'h21);
    do_write(3, 8'h42);
    idle(3);
    do_swap();
    read_check(3, OPAQUE_FIRST ? 8'h21 : 8'h42, "t4_priority");

    // T5: swap while a write is in flight
    WR = 1'b1; WAD = 4'd7; WDI = 8'h55;
    @(negedge CLK);
    WR = 1'b0; SWAP = 1'b1;
    @(negedge CLK);
    SWAP = 1'b0;
    @(negedge CLK);
    read_check(7, 8'h55, "t5_inflight_swap");

    // T6: swap, read and write on the same edge
    do_write(9, 8'h66);
    idle(3);
    do_swap();
    check_output("t6_bank_before", 32'(BANK), 32'h0);
    SWAP = 1'b1; RD = 1'b1; RAD = 4'd9; WR = 1'b1; WAD = 4'd9; WDI = 8'h77;
    @(negedge CLK);
    SWAP = 1'b0; RD = 1'b0; WR = 1'b0;
    @(negedge CLK);
    check_output("t6_read_old_display", 32'(DO), 32'h66);
    check_output("t6_bank_toggled_once", 32'(BANK), 32'h1);
    idle(2);
    read_check(9, 8'h77, "t6_write_old_writebank");

    // Randomized traffic with one mid-run reset
    apply_stimulus(1500);
    idle(NCELL + 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
